// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Purpose:
//   Hazard controller for a 4-register pipeline (PC, IF/ID, ID/EX, EX/MEM).
//   It generates the Stall/Flush controls for three situations:
//     * load-use hazards: the ID instruction reads the destination of a load
//       that is currently in EX. LOAD_LAT bubbles are inserted.
//     * taken branches resolved in EX: the two wrong-path instructions in
//       IF/ID and ID/EX are flushed.
//     * data memory busy: the whole pipe is frozen.
//   Outputs are Mealy: a function of the current FSM state and the inputs,
//   so the response appears in the same cycle as the triggering inputs.
//
// Parameters:
//   LOAD_LAT   bubbles per load-use hazard, legal range 1..7 (default 1).
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   Rn, Rm     in   3  ID-stage source register numbers
//   useRn/useRm in  1  ID instruction really reads Rn / Rm
//   RdP        in   3  EX-stage destination register
//   loadsP     in   1  EX instruction is a load
//   REGWRITEP  in   1  EX instruction writes the register file
//   br_taken   in   1  EX resolved a taken branch this cycle
//   mem_busy   in   1  data memory not ready
//   Stall1..4  out  1  hold PC, IF/ID, ID/EX, EX/MEM
//   Flush2/3   out  1  clear IF/ID, ID/EX
//   hz_state   out  2  FSM state: 0 RUN, 1 LU_WAIT, 2 MEM_WAIT
//   stall_cnt  out 16  (only with HAZARD_STALL_CNT_EN) saturating count of
//                      cycles with Stall1 asserted
//
// Optional feature macro: HAZARD_STALL_CNT_EN
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int LOAD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] Rn,
  input  logic [2:0] Rm,
  input  logic       useRn,
  input  logic       useRm,
  input  logic [2:0] RdP,
  input  logic       loadsP,
  input  logic       REGWRITEP,
  input  logic       br_taken,
  input  logic       mem_busy,
`ifdef HAZARD_STALL_CNT_EN
  output logic [15:0] stall_cnt,
`endif
  output logic       Stall1,
  output logic       Stall2,
  output logic       Stall3,
  output logic       Stall4,
  output logic       Flush2,
  output logic       Flush3,
  output logic [1:0] hz_state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Remaining bubbles after the first one, which is issued from RUN.
  localparam logic [2:0] LU_INIT = 3'(LOAD_LAT - 1);

  state_t     state_reg, state_next;
  state_t     ret_state_reg, ret_state_next;
  logic [2:0] lu_cnt_reg, lu_cnt_next;

  logic       lu;
  logic       stall1_c, stall2_c, stall3_c, stall4_c;
  logic       flush2_c, flush3_c;

  // Load-use hazard: the EX load writes a register the ID instruction reads.
  assign lu = loadsP & REGWRITEP &
              ((useRn & (RdP == Rn)) | (useRm & (RdP == Rm)));

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      ret_state_reg <= RUN;
      lu_cnt_reg    <= 3'd0;
    end else begin
      state_reg     <= state_next;
      ret_state_reg <= ret_state_next;
      lu_cnt_reg    <= lu_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and Mealy output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    ret_state_next = ret_state_reg;
    lu_cnt_next    = lu_cnt_reg;
    stall1_c       = 1'b0;
    stall2_c       = 1'b0;
    stall3_c       = 1'b0;
    stall4_c       = 1'b0;
    flush2_c       = 1'b0;
    flush3_c       = 1'b0;

    unique case (state_reg)
      RUN: begin
        if (mem_busy) begin
          // Memory wins over a simultaneous branch: the branch stays in EX
          // (EX/MEM is held) and is acted on once the freeze ends.
          stall1_c       = 1'b1;
          stall2_c       = 1'b1;
          stall3_c       = 1'b1;
          stall4_c       = 1'b1;
          state_next     = MEM_WAIT;
          ret_state_next = RUN;
        end else if (br_taken) begin
          flush2_c = 1'b1;
          flush3_c = 1'b1;
        end else if (lu) begin
          // Bubble: hold PC and IF/ID, inject a NOP into ID/EX. Stall3 stays
          // low so the ID/EX flush is never masked.
          stall1_c = 1'b1;
          stall2_c = 1'b1;
          flush3_c = 1'b1;
          if (LOAD_LAT > 1) begin
            state_next  = LU_WAIT;
            lu_cnt_next = LU_INIT;
          end
        end
      end

      LU_WAIT: begin
        // EX holds a bubble here, so br_taken and lu are meaningless.
        if (mem_busy) begin
          stall1_c       = 1'b1;
          stall2_c       = 1'b1;
          stall3_c       = 1'b1;
          stall4_c       = 1'b1;
          state_next     = MEM_WAIT;
          ret_state_next = LU_WAIT;
          // lu_cnt keeps its value so the interrupted bubbles resume.
        end else begin
          stall1_c    = 1'b1;
          stall2_c    = 1'b1;
          flush3_c    = 1'b1;
          lu_cnt_next = lu_cnt_reg - 3'd1;
          // <= 1 rather than == 1 so a corrupted zero count cannot wrap and
          // hang the pipe for eight cycles.
          if (lu_cnt_reg <= 3'd1) begin
            state_next = RUN;
          end
        end
      end

      MEM_WAIT: begin
        // Freeze continues for one cycle after mem_busy drops: that cycle
        // captures the memory data.
        stall1_c = 1'b1;
        stall2_c = 1'b1;
        stall3_c = 1'b1;
        stall4_c = 1'b1;
        if (!mem_busy) begin
          state_next = ret_state_reg;
        end
      end

      default: begin
        state_next     = RUN;
        ret_state_next = RUN;
        lu_cnt_next    = 3'd0;
      end
    endcase
  end

  // While reset is asserted the FSM already sits in RUN, but RUN responds
  // combinationally to mem_busy/br_taken/lu, so the outputs are gated.
  assign Stall1   = stall1_c & rst_n;
  assign Stall2   = stall2_c & rst_n;
  assign Stall3   = stall3_c & rst_n;
  assign Stall4   = stall4_c & rst_n;
  assign Flush2   = flush2_c & rst_n;
  assign Flush3   = flush3_c & rst_n;
  assign hz_state = state_reg;

`ifdef HAZARD_STALL_CNT_EN
  // -------------------------------------------------------------------------
  // Saturating count of cycles in which the PC was held.
  // -------------------------------------------------------------------------
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= 16'd0;
    end else if (stall1_c && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed bench for pipeline_hazard_ctrl. Three instances share one set of
// inputs: u1 (LOAD_LAT=1), u2 (LOAD_LAT=2) and u3 (LOAD_LAT=3). Each
// instance's controls are gathered as {Stall1,Stall2,Stall3,Stall4,Flush2,
// Flush3}. Inputs change 1 ns after a rising edge, outputs are checked 1 ns
// later, well clear of the next edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] STALL = 6'b111100;
  localparam logic [5:0] BUB   = 6'b110001;
  localparam logic [5:0] FL    = 6'b000011;

  logic       clk;
  logic       rst_n;
  logic [2:0] Rn, Rm, RdP;
  logic       useRn, useRm, loadsP, REGWRITEP, br_taken, mem_busy;
  logic [5:0] o1, o2, o3;
  logic [1:0] hz1, hz2, hz3;
`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] sc1, sc2, sc3;
`endif

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LOAD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .Rn(Rn), .Rm(Rm), .useRn(useRn), .useRm(useRm),
    .RdP(RdP), .loadsP(loadsP), .REGWRITEP(REGWRITEP), .br_taken(br_taken),
    .mem_busy(mem_busy),
`ifdef HAZARD_STALL_CNT_EN
    .stall_cnt(sc1),
`endif
    .Stall1(o1[5]), .Stall2(o1[4]), .Stall3(o1[3]), .Stall4(o1[2]),
    .Flush2(o1[1]), .Flush3(o1[0]), .hz_state(hz1)
  );

  pipeline_hazard_ctrl #(.LOAD_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .Rn(Rn), .Rm(Rm), .useRn(useRn), .useRm(useRm),
    .RdP(RdP), .loadsP(loadsP), .REGWRITEP(REGWRITEP), .br_taken(br_taken),
    .mem_busy(mem_busy),
`ifdef HAZARD_STALL_CNT_EN
    .stall_cnt(sc2),
`endif
    .Stall1(o2[5]), .Stall2(o2[4]), .Stall3(o2[3]), .Stall4(o2[2]),
    .Flush2(o2[1]), .Flush3(o2[0]), .hz_state(hz2)
  );

  pipeline_hazard_ctrl #(.LOAD_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .Rn(Rn), .Rm(Rm), .useRn(useRn), .useRm(useRm),
    .RdP(RdP), .loadsP(loadsP), .REGWRITEP(REGWRITEP), .br_taken(br_taken),
    .mem_busy(mem_busy),
`ifdef HAZARD_STALL_CNT_EN
    .stall_cnt(sc3),
`endif
    .Stall1(o3[5]), .Stall2(o3[4]), .Stall3(o3[3]), .Stall4(o3[2]),
    .Flush2(o3[1]), .Flush3(o3[0]), .hz_state(hz3)
  );

  // Invariant: Flush3 and Stall3 never high together in any instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ((o1[3] & o1[0]) | (o2[3] & o2[0]) | (o3[3] & o3[0])) begin
        errors++;
        $display("FAIL flush3_stall3_excl o1=%b o2=%b o3=%b required Stall3&Flush3=0", o1, o2, o3);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rn = 3'd0; Rm = 3'd0; RdP = 3'd0;
    useRn = 1'b0; useRm = 1'b0; loadsP = 1'b0; REGWRITEP = 1'b0;
    br_taken = 1'b0; mem_busy = 1'b0;
  endtask

  // Load in EX writes r3, ID reads r3 through Rm.
  task automatic set_lu_rm();
    RdP = 3'd3; loadsP = 1'b1; REGWRITEP = 1'b1; Rm = 3'd3; useRm = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    mem_busy = 1'b1;
    tick();
    checks++;
    if (o1 !== NONE) begin errors++; $display("FAIL rst_hold_u1 got=%b need=%b", o1, NONE); end
    checks++;
    if (o3 !== NONE) begin errors++; $display("FAIL rst_hold_u3 got=%b need=%b", o3, NONE); end
    checks++;
    if (hz1 !== 2'd0) begin errors++; $display("FAIL rst_hz got=%0d need=0", hz1); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (o1 !== STALL) begin errors++; $display("FAIL rst_release_stall got=%b need=%b", o1, STALL); end
    tick();
    mem_busy = 1'b0;
    #1;
    checks++;
    if (o1 !== STALL || hz1 !== 2'd2) begin
      errors++; $display("FAIL rst_capture_cycle got=%b hz=%0d need=%b hz=2", o1, hz1, STALL);
    end
    tick();
    checks++;
    if (o1 !== NONE || hz1 !== 2'd0) begin
      errors++; $display("FAIL rst_back_to_run got=%b hz=%0d need=%b hz=0", o1, hz1, NONE);
    end
    $display("test_reset done");
  endtask

  task automatic test_lu_lat1();
    set_lu_rm();
    #1;
    checks++;
    if (o1 !== BUB || hz1 !== 2'd0) begin
      errors++; $display("FAIL lu1_bubble got=%b hz=%0d need=%b hz=0", o1, hz1, BUB);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (o1 !== NONE || hz1 !== 2'd0) begin
      errors++; $display("FAIL lu1_single got=%b hz=%0d need=%b hz=0", o1, hz1, NONE);
    end
    tick(); tick(); tick();
    // Same registers but Rm not actually read: no hazard.
    set_lu_rm();
    useRm = 1'b0;
    #1;
    checks++;
    if (o1 !== NONE || o3 !== NONE) begin
      errors++; $display("FAIL lu_unused_rm got=%b/%b need=%b", o1, o3, NONE);
    end
    // Rn path.
    clear_inputs();
    RdP = 3'd5; loadsP = 1'b1; REGWRITEP = 1'b1; Rn = 3'd5; useRn = 1'b1; Rm = 3'd2; useRm = 1'b1;
    #1;
    checks++;
    if (o1 !== BUB) begin errors++; $display("FAIL lu_rn_path got=%b need=%b", o1, BUB); end
    // Not a register write: no hazard.
    REGWRITEP = 1'b0;
    #1;
    checks++;
    if (o1 !== NONE) begin errors++; $display("FAIL lu_no_regwrite got=%b need=%b", o1, NONE); end
    // Not a load: no hazard.
    REGWRITEP = 1'b1; loadsP = 1'b0;
    #1;
    checks++;
    if (o1 !== NONE) begin errors++; $display("FAIL lu_not_load got=%b need=%b", o1, NONE); end
    // Register mismatch: no hazard.
    loadsP = 1'b1; Rn = 3'd4;
    #1;
    checks++;
    if (o1 !== NONE) begin errors++; $display("FAIL lu_reg_mismatch got=%b need=%b", o1, NONE); end
    clear_inputs();
    tick();
    $display("test_lu_lat1 done");
  endtask

  task automatic test_lu_lat3_mem();
    logic [5:0] exp_o [0:6];
    logic [1:0] exp_hz [0:6];
    exp_o  = '{BUB, STALL, STALL, STALL, BUB, BUB, NONE};
    exp_hz = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
    for (int c = 0; c < 7; c++) begin
      clear_inputs();
      if (c == 0) set_lu_rm();
      if (c == 1 || c == 2) mem_busy = 1'b1;
      // Branch and a fresh hazard during LU_WAIT must be ignored.
      if (c == 4) br_taken = 1'b1;
      if (c == 5) set_lu_rm();
      #1;
      checks++;
      if (o3 !== exp_o[c] || hz3 !== exp_hz[c]) begin
        errors++;
        $display("FAIL lu3_mem_cycle%0d got=%b hz=%0d need=%b hz=%0d", c, o3, hz3, exp_o[c], exp_hz[c]);
      end
      tick();
    end
    clear_inputs();
    tick(); tick();
    $display("test_lu_lat3_mem done");
  endtask

  task automatic test_branch();
    br_taken = 1'b1;
    #1;
    checks++;
    if (o1 !== FL || o3 !== FL) begin
      errors++; $display("FAIL branch_flush got=%b/%b need=%b", o1, o3, FL);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (o1 !== NONE || o3 !== NONE) begin
      errors++; $display("FAIL branch_one_cycle got=%b/%b need=%b", o1, o3, NONE);
    end
    // Branch outranks a load-use hazard.
    br_taken = 1'b1;
    set_lu_rm();
    #1;
    checks++;
    if (o3 !== FL || hz3 !== 2'd0) begin
      errors++; $display("FAIL branch_over_lu got=%b hz=%0d need=%b hz=0", o3, hz3, FL);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (o3 !== NONE || hz3 !== 2'd0) begin
      errors++; $display("FAIL branch_lu_dropped got=%b hz=%0d need=%b hz=0", o3, hz3, NONE);
    end
    tick();
    $display("test_branch done");
  endtask

  task automatic test_simultaneous();
    logic [5:0] exp_o [0:4];
    exp_o = '{STALL, STALL, STALL, FL, NONE};
    for (int c = 0; c < 5; c++) begin
      clear_inputs();
      br_taken = (c <= 3);
      mem_busy = (c <= 1);
      #1;
      checks++;
      if (o1 !== exp_o[c]) begin
        errors++; $display("FAIL simul_cycle%0d got=%b need=%b", c, o1, exp_o[c]);
      end
      tick();
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp1 [0:3];
    logic [5:0] exp3 [0:3];
    exp1 = '{BUB, BUB, NONE, NONE};
    exp3 = '{BUB, BUB, BUB, NONE};
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      if (c < 2) set_lu_rm();
      #1;
      checks++;
      if (o1 !== exp1[c] || o3 !== exp3[c]) begin
        errors++; $display("FAIL b2b_cycle%0d got=%b/%b need=%b/%b", c, o1, o3, exp1[c], exp3[c]);
      end
      tick();
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid_stall();
    clear_inputs();
    mem_busy = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (o1 !== NONE || hz1 !== 2'd0 || hz3 !== 2'd0) begin
      errors++; $display("FAIL rst_mid_stall got=%b hz=%0d/%0d need=%b hz=0", o1, hz1, hz3, NONE);
    end
    mem_busy = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (o1 !== NONE || hz1 !== 2'd0) begin
      errors++; $display("FAIL rst_mid_release got=%b hz=%0d need=%b hz=0", o1, hz1, NONE);
    end
    tick();
    $display("test_reset_mid_stall done");
  endtask

`ifdef HAZARD_STALL_CNT_EN
  task automatic test_stall_cnt();
    rst_n = 1'b0;
    clear_inputs();
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (sc2 !== 16'd0) begin errors++; $display("FAIL cnt_reset got=%0d need=0", sc2); end
    for (int e = 0; e < 4; e++) begin
      set_lu_rm();
      tick();
      clear_inputs();
      tick();
      tick();
    end
    checks++;
    if (sc2 !== 16'd8) begin errors++; $display("FAIL cnt_lu4 got=%0d need=8", sc2); end
    mem_busy = 1'b1;
    repeat (65540) tick();
    checks++;
    if (sc2 !== 16'hFFFF) begin errors++; $display("FAIL cnt_saturate got=%h need=ffff", sc2); end
    mem_busy = 1'b0;
    tick(); tick();
    checks++;
    if (sc2 !== 16'hFFFF) begin errors++; $display("FAIL cnt_hold got=%h need=ffff", sc2); end
    $display("test_stall_cnt done");
  endtask
`endif

  initial begin
    test_reset();
    test_lu_lat1();
    test_lu_lat3_mem();
    test_branch();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_stall();
`ifdef HAZARD_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
